// File: rtl/stark_sau_issue_queue_if.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg + stark_sau_issue_queue_if
//
// Purpose: shared CPU types used by the SAU issue queue, and the interface
// bundle that carries dispatch, bypass, stomp and issue traffic between the
// queue and its surroundings.
//
// The package is kept here so the queue has a single home for its types.
//
// Interface signals (directions named from the queue's point of view):
//   disp_v_i, disp_rse_i, disp_tag_i, disp_argv_i : dispatch request
//   rdy_o                                         : queue has a free entry
//   byp_v_i, byp_tag_i, byp_val_i                 : result bypass buses
//   stall_i                                       : SAU refuses issue
//   stomp_i                                       : ROB squash mask
//   rse_o                                         : registered issue to SAU
//   count_o                                       : occupied entries
// Modports: master = dispatch/SAU side, slave = the issue queue.
// ---------------------------------------------------------------------------
package cpu_types_pkg;
  typedef logic [31:0] value_t;
  typedef logic [15:0] rob_bitmask_t;
  typedef logic [3:0]  rob_ndx_t;

  typedef struct packed {
    logic     v;
    rob_ndx_t rndx;
    logic [7:0] op;
    value_t   argA;
    value_t   argB;
    value_t   argC;
    value_t   argD;
  } reservation_station_entry_t;
endpackage

interface stark_sau_issue_queue_if #(
  parameter int NENT = 4,
  parameter int NBYP = 2,
  parameter int TAGW = 9,
  parameter int WID  = $bits(cpu_types_pkg::value_t)
);
  import cpu_types_pkg::*;

  logic                            disp_v_i;
  reservation_station_entry_t      disp_rse_i;
  logic [3:0][TAGW-1:0]            disp_tag_i;
  logic [3:0]                      disp_argv_i;
  logic                            rdy_o;
  logic [NBYP-1:0]                 byp_v_i;
  logic [NBYP-1:0][TAGW-1:0]       byp_tag_i;
  logic [NBYP-1:0][WID-1:0]        byp_val_i;
  logic                            stall_i;
  rob_bitmask_t                    stomp_i;
  reservation_station_entry_t      rse_o;
  logic [$clog2(NENT+1)-1:0]       count_o;

  modport master (
    output disp_v_i, disp_rse_i, disp_tag_i, disp_argv_i,
    output byp_v_i, byp_tag_i, byp_val_i, stall_i, stomp_i,
    input  rdy_o, rse_o, count_o
  );

  modport slave (
    input  disp_v_i, disp_rse_i, disp_tag_i, disp_argv_i,
    input  byp_v_i, byp_tag_i, byp_val_i, stall_i, stomp_i,
    output rdy_o, rse_o, count_o
  );
endinterface

// File: rtl/stark_sau_issue_queue.sv
// ---------------------------------------------------------------------------
// stark_sau_issue_queue
//
// Purpose: reservation-station issue queue in front of a Stark_meta_sau lane.
// Holds up to NENT dispatched entries, snoops NBYP bypass buses for missing
// operands, and each cycle issues the oldest entry whose four operands are
// valid onto a registered rse_o. Entries named in the ROB stomp mask are
// dropped without issuing.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   io   : stark_sau_issue_queue_if.slave (dispatch, bypass, stall, stomp,
//          rse_o issue, rdy_o, count_o)
// ---------------------------------------------------------------------------
module stark_sau_issue_queue
  import cpu_types_pkg::*;
#(
  parameter int NENT = 4,
  parameter int NBYP = 2,
  parameter int TAGW = 9,
  parameter int WID  = $bits(cpu_types_pkg::value_t)
) (
  input  logic                    clk,
  input  logic                    rst,
  stark_sau_issue_queue_if.slave  io
);

  localparam int CW = $clog2(NENT + 1);
  localparam int IW = (NENT > 1) ? $clog2(NENT) : 1;

  typedef logic [3:0][TAGW-1:0] tags_t;
  typedef logic [3:0][WID-1:0]  args_t;

  logic [NENT-1:0]            busy_q, busy_d;
  reservation_station_entry_t ent_q   [NENT];
  reservation_station_entry_t ent_d   [NENT];
  tags_t                      tag_q   [NENT];
  tags_t                      tag_d   [NENT];
  logic [3:0]                 argv_q  [NENT];
  logic [3:0]                 argv_d  [NENT];
  args_t                      arg_q   [NENT];
  args_t                      arg_d   [NENT];
  // older_q[i][j] = 1 means entry j is older than entry i.
  logic [NENT-1:0]            older_q [NENT];
  logic [NENT-1:0]            older_d [NENT];
  reservation_station_entry_t rse_q, rse_d;

  logic [NENT-1:0]            stomped, ready, sel;
  logic                       issue;
  logic                       accept;
  logic [IW-1:0]              free_idx;
  reservation_station_entry_t issue_ent;
  logic [CW-1:0]              count;

  // Ready/select. An entry is picked only if no older entry is also ready;
  // since the age matrix totally orders busy entries, sel is one-hot or zero.
  always_comb begin
    stomped = '0;
    ready   = '0;
    sel     = '0;
    for (int i = 0; i < NENT; i++) begin
      stomped[i] = busy_q[i] & io.stomp_i[ent_q[i].rndx];
      ready[i]   = busy_q[i] & (&argv_q[i]) & ~stomped[i];
    end
    for (int i = 0; i < NENT; i++) begin
      sel[i] = ready[i] & ~(|(older_q[i] & ready));
    end
  end

  assign issue = (|sel) & ~io.stall_i;

  // Lowest-index free slot; rdy_o looks only at registered busy, so a slot
  // freed this cycle is not offered until the next one.
  always_comb begin
    free_idx = '0;
    for (int i = NENT - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  assign accept = io.disp_v_i & ~(&busy_q) & ~io.stomp_i[io.disp_rse_i.rndx];

  // Entry state update: drop on stomp/issue, operand capture from bypass,
  // and insertion of a new dispatch. Buses are scanned high to low so that
  // the lowest-numbered matching bus is the last writer and wins.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NENT; i++) begin
      ent_d[i]   = ent_q[i];
      tag_d[i]   = tag_q[i];
      argv_d[i]  = argv_q[i];
      arg_d[i]   = arg_q[i];
      older_d[i] = older_q[i];
    end

    for (int i = 0; i < NENT; i++) begin
      if (stomped[i] || (issue && sel[i])) busy_d[i] = 1'b0;
      if (busy_q[i]) begin
        for (int o = 0; o < 4; o++) begin
          if (!argv_q[i][o]) begin
            for (int k = NBYP - 1; k >= 0; k--) begin
              if (io.byp_v_i[k] && (io.byp_tag_i[k] == tag_q[i][o])) begin
                arg_d[i][o]  = io.byp_val_i[k];
                argv_d[i][o] = 1'b1;
              end
            end
          end
        end
      end
    end

    if (accept) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = io.disp_rse_i;
      tag_d[free_idx]  = io.disp_tag_i;
      argv_d[free_idx] = io.disp_argv_i;
      arg_d[free_idx]  = {WID'(io.disp_rse_i.argD), WID'(io.disp_rse_i.argC),
                          WID'(io.disp_rse_i.argB), WID'(io.disp_rse_i.argA)};
      for (int o = 0; o < 4; o++) begin
        if (!io.disp_argv_i[o]) begin
          for (int k = NBYP - 1; k >= 0; k--) begin
            if (io.byp_v_i[k] && (io.byp_tag_i[k] == io.disp_tag_i[o])) begin
              arg_d[free_idx][o]  = io.byp_val_i[k];
              argv_d[free_idx][o] = 1'b1;
            end
          end
        end
      end
      // New entry is younger than every busy entry. Clearing its column
      // wipes stale age bits left over from the slot's previous occupant.
      older_d[free_idx] = busy_q;
      for (int j = 0; j < NENT; j++) begin
        older_d[j][free_idx] = 1'b0;
      end
    end
  end

  // Issue mux: assemble the selected entry with its captured operands. When
  // nothing issues, rse_o keeps its payload and only v drops.
  always_comb begin
    issue_ent = '0;
    for (int i = 0; i < NENT; i++) begin
      if (sel[i]) begin
        issue_ent      = ent_q[i];
        issue_ent.argA = value_t'(arg_q[i][0]);
        issue_ent.argB = value_t'(arg_q[i][1]);
        issue_ent.argC = value_t'(arg_q[i][2]);
        issue_ent.argD = value_t'(arg_q[i][3]);
      end
    end
    rse_d   = rse_q;
    rse_d.v = 1'b0;
    if (issue) begin
      rse_d   = issue_ent;
      rse_d.v = 1'b1;
    end
  end

  // State registers; reset drops every entry and clears the issue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      rse_q  <= '0;
      for (int i = 0; i < NENT; i++) begin
        ent_q[i]   <= '0;
        tag_q[i]   <= '0;
        argv_q[i]  <= '0;
        arg_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      rse_q  <= rse_d;
      for (int i = 0; i < NENT; i++) begin
        ent_q[i]   <= ent_d[i];
        tag_q[i]   <= tag_d[i];
        argv_q[i]  <= argv_d[i];
        arg_q[i]   <= arg_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  // Occupancy is the population count of busy, so it tracks every
  // dispatch/issue/stomp combination applied at one edge.
  always_comb begin
    count = '0;
    for (int i = 0; i < NENT; i++) begin
      count = count + CW'(busy_q[i]);
    end
  end

  assign io.rdy_o   = ~(&busy_q);
  assign io.rse_o   = rse_q;
  assign io.count_o = count;

endmodule
